wb_regfile: RTL and testbench

Writeback stage of the 5-stage RV32I pipeline, directly downstream of the MEM/WB pipeline register. It selects the writeback result, sign- or zero-extends loaded bytes and halfwords, and commits the result into the 32-entry integer register file. It also serves the decode stage's two combinational read ports, with write-through bypass so decode sees a same-cycle writeback without a stall.

---
 rtl/wb_regfile_pkg.sv | 20 ++
 rtl/wb_regfile_load_ext.sv | 42 ++++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage.
// Result-select encodings, load funct3 codes, XLEN.
package wb_regfile_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load data extension: picks byte/half lane and sign/zero extends.
// In: ReadDataW, Funct3W, offset. Out: ext.
module wb_regfile_load_ext
  import wb_regfile_pkg::*;
(
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [2:0]      Funct3W,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ReadDataW[7:0];
    unique case (offset)
      2'd0: byte_sel = ReadDataW[7:0];
      2'd1: byte_sel = ReadDataW[15:8];
      2'd2: byte_sel = ReadDataW[23:16];
      2'd3: byte_sel = ReadDataW[31:24];
      default: byte_sel = ReadDataW[7:0];
    endcase
  end

  // Halfword lane comes from offset[1] only.
  assign half_sel = offset[1] ? ReadDataW[31:16]
                              : ReadDataW[15:0];

  always_comb begin
    ext = ReadDataW;
    case (Funct3W)
      F3_LB:  ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:  ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU: ext = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:  ext = ReadDataW;
      default: ext = ReadDataW;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result mux, load extension, 32-entry regfile
// with two bypassed decode read ports (Rs1D/Rs2D -> RD1D/RD2D).
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcW,
  input  logic [2:0]        Funct3W,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] PCPlus4W,
  input  logic [DATA_W-1:0] ImmExtW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] rf [NREG];
  logic              wr_en;
  logic              hit1;
  logic              hit2;

  wb_regfile_load_ext u_load_ext (
    .ReadDataW (ReadDataW),
    .Funct3W   (Funct3W),
    .offset    (ALUResultW[1:0]),
    .ext       (load_data)
  );

  always_comb begin
    ResultW = ALUResultW;
    unique case (res_src_e'(ResultSrcW))
      RES_ALU: ResultW = ALUResultW;
      RES_MEM: ResultW = load_data;
      RES_PC4: ResultW = PCPlus4W;
      RES_IMM: ResultW = ImmExtW;
      default: ResultW = ALUResultW;
    endcase
  end

  assign wr_en = RegWriteW && (RdW != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[RdW] <= ResultW;
    end
  end

  // wr_en already excludes x0, so a pending x0 write never bypasses.
  assign hit1 = wr_en && (RdW == Rs1D);
  assign hit2 = wr_en && (RdW == Rs2D);

  always_comb begin
    RD1D = '0;
    if (Rs1D != '0) begin
      RD1D = hit1 ? ResultW : rf[Rs1D];
    end
  end

  always_comb begin
    RD2D = '0;
    if (Rs2D != '0) begin
      RD2D = hit2 ? ResultW : rf[Rs2D];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile.
// Hand-computed vectors for mux, load extension, writes and bypass.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [2:0]  Funct3W;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [31:0] ImmExtW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .Funct3W    (Funct3W),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .ImmExtW    (ImmExtW),
    .RdW        (RdW),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] f3,
                    input logic [1:0] off,
                    input logic [31:0] exp,
                    input string tag);
    Funct3W    = f3;
    ALUResultW = 32'h0000_1000 | {30'd0, off};
    #1;
    check(tag, ResultW, exp);
  endtask

  initial begin
    reset      = 1'b1;
    RegWriteW  = 1'b0;
    ResultSrcW = 2'b00;
    Funct3W    = 3'b000;
    ALUResultW = '0;
    ReadDataW  = '0;
    PCPlus4W   = '0;
    ImmExtW    = '0;
    RdW        = '0;
    Rs1D       = '0;
    Rs2D       = '0;
    tick();
    tick();

    // write attempt under reset is dropped
    RegWriteW  = 1'b1;
    RdW        = 5'd5;
    ALUResultW = 32'hDEAD_BEEF;
    tick();
    reset     = 1'b0;
    RegWriteW = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Rs1D = 5'(i);
      Rs2D = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_x%0d", i), RD1D, 32'h0);
      check($sformatf("rst_rd2_x%0d", 31 - i), RD2D, 32'h0);
    end

    // load extension
    ResultSrcW = 2'b01;
    ReadDataW  = 32'h80F1_7F82;
    ld(3'b000, 2'd0, 32'hFFFF_FF82, "lb_off0");
    ld(3'b000, 2'd1, 32'h0000_007F, "lb_off1");
    ld(3'b000, 2'd2, 32'hFFFF_FFF1, "lb_off2");
    ld(3'b000, 2'd3, 32'hFFFF_FF80, "lb_off3");
    ld(3'b100, 2'd3, 32'h0000_0080, "lbu_off3");
    ld(3'b100, 2'd2, 32'h0000_00F1, "lbu_off2");
    ld(3'b001, 2'd2, 32'hFFFF_80F1, "lh_off2");
    ld(3'b001, 2'd1, 32'h0000_7F82, "lh_off1");
    ld(3'b101, 2'd0, 32'h0000_7F82, "lhu_off0");
    ld(3'b101, 2'd3, 32'h0000_80F1, "lhu_off3");
    ld(3'b010, 2'd3, 32'h80F1_7F82, "lw_off3");
    ld(3'b011, 2'd1, 32'h80F1_7F82, "f3_011");
    ld(3'b110, 2'd2, 32'h80F1_7F82, "f3_110");
    ld(3'b111, 2'd3, 32'h80F1_7F82, "f3_111");

    // result select
    ALUResultW = 32'h0000_0011;
    PCPlus4W   = 32'h0000_1004;
    ImmExtW    = 32'hABCD_E000;
    ResultSrcW = 2'b00;
    #1 check("sel_alu", ResultW, 32'h0000_0011);
    ResultSrcW = 2'b10;
    #1 check("sel_pc4", ResultW, 32'h0000_1004);
    ResultSrcW = 2'b11;
    #1 check("sel_imm", ResultW, 32'hABCD_E000);
    RegWriteW = 1'b1;
    RdW       = 5'd7;
    tick();
    RegWriteW = 1'b0;
    Rs1D      = 5'd7;
    Rs2D      = 5'd7;
    #1;
    check("x7_rd1", RD1D, 32'hABCD_E000);
    check("x7_rd2", RD2D, 32'hABCD_E000);

    // x0 write discarded
    ResultSrcW = 2'b00;
    ALUResultW = 32'h0000_1234;
    RegWriteW  = 1'b1;
    RdW        = 5'd0;
    Rs1D       = 5'd0;
    #1;
    check("x0_res", ResultW, 32'h0000_1234);
    check("x0_byp", RD1D, 32'h0);
    tick();
    RegWriteW = 1'b0;
    #1 check("x0_after", RD1D, 32'h0);

    // bypass on both ports
    RegWriteW  = 1'b1;
    RdW        = 5'd9;
    ALUResultW = 32'h0000_0001;
    tick();
    ALUResultW = 32'h0000_55AA;
    Rs1D       = 5'd9;
    Rs2D       = 5'd9;
    #1;
    check("byp_rd1", RD1D, 32'h0000_55AA);
    check("byp_rd2", RD2D, 32'h0000_55AA);
    RegWriteW = 1'b0;
    #1;
    check("nobyp_rd1", RD1D, 32'h0000_0001);
    check("nobyp_rd2", RD2D, 32'h0000_0001);

    // back-to-back writes then reset
    RegWriteW  = 1'b1;
    RdW        = 5'd3;
    ALUResultW = 32'h0000_000A;
    Rs1D       = 5'd3;
    Rs2D       = 5'd3;
    tick();
    RegWriteW = 1'b0;
    #1 check("x3_a", RD1D, 32'h0000_000A);
    RegWriteW  = 1'b1;
    ALUResultW = 32'h0000_000B;
    tick();
    RegWriteW = 1'b0;
    #1 check("x3_b", RD2D, 32'h0000_000B);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("x3_rst", RD1D, 32'h0);
    Rs1D = 5'd7;
    Rs2D = 5'd9;
    #1;
    check("x7_rst", RD1D, 32'h0);
    check("x9_rst", RD2D, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
